rr_ring_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource (the 4-stage ring counter datapath or any single-owner unit) among N requesters.
- Priority is held in a one-hot rotating token, the same structure as the lab ring counter.
- A small FSM issues registered one-hot grants, bounds ownership with a hold timer, and inserts a one-cycle handover gap.
- Sits between requester blocks and the shared resource's enable/select inputs.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 25 ++
 rtl/rr_ring_arbiter.sv | 106 ++++++++++
 tb/tb_rr_ring_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin ring arbiter: FSM state encoding,
// the default hold limit and a one-hot to binary index helper.
package arb_pkg;

  localparam int DEFAULT_MAX_HOLD = 8;
  localparam int MAX_REQ          = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Input is zero-extended to MAX_REQ bits; OR-ing indices is exact for one-hot input.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select: first requester at or after the
// token position, wrapping from N-1 back to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4
)(
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_token,
  output logic [N-1:0] o_winner
);

  logic [2*N-1:0] w_req_dbl;
  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_masked;
  logic [2*N-1:0] w_first;

  assign w_req_dbl = {i_req, i_req};
  // Keep positions at or above the token; the upper copy of req supplies the wrap-around.
  assign w_mask    = ~({{N{1'b0}}, i_token} - {{(2*N-1){1'b0}}, 1'b1});
  assign w_masked  = w_req_dbl & w_mask;
  assign w_first   = w_masked & (~w_masked + {{(2*N-1){1'b0}}, 1'b1});
  assign o_winner  = w_first[N-1:0] | w_first[2*N-1:N];

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot token, bounded ownership via a
// hold timer, and a one-cycle handover gap between owners.
module rr_ring_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter  int CNT_W    = 8,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
)(
  input  logic           clk,
  input  logic           clear,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           preempt,
  output logic           busy
);

  arb_state_e     r_state;
  logic [N-1:0]   r_token;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [N-1:0]   r_grant;
  logic           r_grant_valid;
  logic [IDW-1:0] r_grant_id;
  logic           r_preempt;
  logic           r_busy;

  logic [N-1:0]   w_winner;
  logic [IDW-1:0] w_winner_id;
  logic [N-1:0]   w_token_next;
  logic           w_owner_req;
  logic           w_any_req;
  logic           w_timeout;

  rr_pick #(.N(N)) u_pick (
    .i_req    (req),
    .i_token  (r_token),
    .o_winner (w_winner)
  );

  assign w_winner_id  = IDW'(onehot_to_idx(MAX_REQ'(w_winner)));
  assign w_token_next = {r_grant[N-2:0], r_grant[N-1]};
  assign w_owner_req  = |(req & r_grant);
  assign w_any_req    = |req;
  assign w_timeout    = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state       <= ST_IDLE;
      r_token       <= N'(1);
      r_hold_cnt    <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_preempt     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        // RELEASE arbitrates exactly like IDLE, but with the already-advanced token.
        ST_IDLE, ST_RELEASE: begin
          if (w_any_req) begin
            r_state       <= ST_GRANT;
            r_grant       <= w_winner;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_winner_id;
            r_hold_cnt    <= '0;
            r_busy        <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!w_owner_req || w_timeout) begin
            r_state       <= ST_RELEASE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_token       <= w_token_next;
            r_preempt     <= w_owner_req;
            r_busy        <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_grant_id    <= '0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign preempt     = r_preempt;
  assign busy        = r_busy;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Self-checking bench for rr_ring_arbiter: a behavioural model fills a
// scoreboard queue per driven cycle, plus directed checks on key sequences.
module tb_rr_ring_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  typedef struct packed {
    logic [3:0] grant;
    logic       valid;
    logic [1:0] id;
    logic       preempt;
    logic       busy;
  } expect_t;

  logic       clk;
  logic       clear;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grantValid;
  logic [1:0] grantId;
  logic       preempt;
  logic       busy;

  expect_t sbQueue[$];
  int assertCount;
  int failCount;

  int mState;
  int mTok;
  int mOwner;
  int mHold;

  logic [3:0] reqVal;
  logic [3:0] prevGrant;
  logic [3:0] prevReq;
  logic [3:0] expG;
  logic       expP;
  int         nGrants;
  int         gapLen;
  logic [3:0] seqObs [5];
  logic [3:0] expSeq [5];
  logic [3:0] reqTab [10];
  logic [3:0] gTab   [10];

  rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk         (clk),
    .clear       (clear),
    .req         (req),
    .grant       (grant),
    .grant_valid (grantValid),
    .grant_id    (grantId),
    .preempt     (preempt),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int pickModel(input logic [3:0] r, input int tok);
    for (int k = 0; k < N; k++) begin
      if (r[(tok + k) % N]) return (tok + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [1:0] idxOf(input logic [3:0] g);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Behavioural model: computes what the DUT must show after the coming edge.
  task automatic modelStep(input logic [3:0] r);
    expect_t e;
    e = '0;
    if (mState == 1) begin
      if (!r[mOwner] || mHold == MAX_HOLD - 1) begin
        e.preempt = r[mOwner];
        e.busy    = 1'b1;
        mTok      = (mOwner + 1) % N;
        mState    = 2;
      end else begin
        mHold++;
        e.grant = 4'(1 << mOwner);
        e.valid = 1'b1;
        e.id    = 2'(mOwner);
        e.busy  = 1'b1;
      end
    end else if (r != 4'b0000) begin
      mOwner  = pickModel(r, mTok);
      mHold   = 0;
      mState  = 1;
      e.grant = 4'(1 << mOwner);
      e.valid = 1'b1;
      e.id    = 2'(mOwner);
      e.busy  = 1'b1;
    end else begin
      mState = 0;
    end
    sbQueue.push_back(e);
  endtask

  task automatic compareScoreboard();
    expect_t e;
    checkOutput("sb_depth", 32'(sbQueue.size()), 1);
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput("sb_grant", 32'(grant), 32'(e.grant));
      checkOutput("sb_valid", 32'(grantValid), 32'(e.valid));
      checkOutput("sb_id", 32'(grantId), 32'(e.id));
      checkOutput("sb_preempt", 32'(preempt), 32'(e.preempt));
      checkOutput("sb_busy", 32'(busy), 32'(e.busy));
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    modelStep(r);
    @(posedge clk);
    #1;
    compareScoreboard();
  endtask

  task automatic resetModel();
    mState = 0;
    mTok   = 0;
    mOwner = 0;
    mHold  = 0;
    sbQueue.delete();
  endtask

  task automatic doReset();
    req   = 4'b0000;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_valid", 32'(grantValid), 0);
    checkOutput("rst_id", 32'(grantId), 0);
    checkOutput("rst_preempt", 32'(preempt), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    clear = 1'b1;
    resetModel();
  endtask

  // Structural invariants, sampled away from the active edge.
  always @(negedge clk) begin
    checkOutput("inv_onehot0", 32'($onehot0(grant)), 1);
    checkOutput("inv_valid", 32'(grantValid), 32'(|grant));
    checkOutput("inv_id", 32'(grantId), 32'(idxOf(grant)));
    checkOutput("inv_token", 32'($onehot(dut.r_token)), 1);
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    req         = 4'b0000;
    clear       = 1'b1;
    resetModel();
    #1;

    // Asynchronous reset while owner 2 holds
    doReset();
    applyStimulus(4'b0100);
    applyStimulus(4'b0100);
    checkOutput("t1_owner2", 32'(grant), 32'h4);
    #2;
    clear = 1'b0;
    #1;
    checkOutput("t1_async_grant", 32'(grant), 0);
    checkOutput("t1_async_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    clear = 1'b1;
    resetModel();
    applyStimulus(4'b1111);
    checkOutput("t1_after_reset", 32'(grant), 32'h1);

    // Fair rotation: each owner drops after 3 grant cycles
    doReset();
    expSeq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    nGrants   = 0;
    gapLen    = 0;
    prevGrant = 4'b0000;
    for (int c = 0; c < 24 && nGrants < 5; c++) begin
      reqVal = 4'b1111;
      if (mState == 1 && mHold == 2) reqVal[mOwner] = 1'b0;
      applyStimulus(reqVal);
      checkOutput("t2_preempt", 32'(preempt), 0);
      if (grant != 4'b0000 && prevGrant == 4'b0000) begin
        if (nGrants > 0) checkOutput("t2_gap", 32'(gapLen), 1);
        seqObs[nGrants] = grant;
        nGrants++;
      end
      gapLen    = (grant == 4'b0000) ? gapLen + 1 : 0;
      prevGrant = grant;
    end
    checkOutput("t2_count", 32'(nGrants), 5);
    for (int i = 0; i < nGrants; i++) checkOutput("t2_seq", 32'(seqObs[i]), 32'(expSeq[i]));

    // Timeout with two constant requesters
    doReset();
    for (int i = 1; i <= 19; i++) begin
      applyStimulus(4'b0011);
      if (i <= 8)       expG = 4'b0001;
      else if (i == 9)  expG = 4'b0000;
      else if (i <= 17) expG = 4'b0010;
      else if (i == 18) expG = 4'b0000;
      else              expG = 4'b0001;
      expP = (i == 9) || (i == 18);
      checkOutput("t3_grant", 32'(grant), 32'(expG));
      checkOutput("t3_preempt", 32'(preempt), 32'(expP));
    end

    // Wrap from token 3 and skip a requester that withdrew
    doReset();
    reqTab = '{4'b0100, 4'b0000, 4'b0000, 4'b0101, 4'b0111,
               4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    gTab   = '{4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0001,
               4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(reqTab[i]);
      checkOutput("t4_grant", 32'(grant), 32'(gTab[i]));
      if (i == 2) checkOutput("t4_token3", 32'(dut.r_token), 32'h8);
    end

    // Owner drops on the same edge the hold timer expires
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(4'b0011);
    checkOutput("t5_hold8", 32'(grant), 32'h1);
    applyStimulus(4'b0010);
    checkOutput("t5_grant", 32'(grant), 0);
    checkOutput("t5_preempt", 32'(preempt), 0);
    checkOutput("t5_busy", 32'(busy), 1);
    applyStimulus(4'b0011);
    checkOutput("t5_token_adv", 32'(grant), 32'h2);

    // Single short request then return to idle
    doReset();
    applyStimulus(4'b0010);
    checkOutput("t6_grant1", 32'(grant), 32'h2);
    checkOutput("t6_id1", 32'(grantId), 1);
    applyStimulus(4'b0010);
    checkOutput("t6_grant2", 32'(grant), 32'h2);
    applyStimulus(4'b0000);
    checkOutput("t6_rel_grant", 32'(grant), 0);
    checkOutput("t6_rel_busy", 32'(busy), 1);
    applyStimulus(4'b0000);
    checkOutput("t6_idle_busy", 32'(busy), 0);
    checkOutput("t6_idle_id", 32'(grantId), 0);

    // Random request traffic against the model
    doReset();
    prevReq = 4'b0000;
    for (int i = 0; i < 200; i++) begin
      reqVal = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : prevReq;
      applyStimulus(reqVal);
      prevReq = reqVal;
    end

    req = 4'b0000;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
